// File: rtl/array_arbiter_pkg.sv
// array_arbiter_pkg
//   Shared widths, FSM encoding and helper for the array arbiter slice.
//   ADDR_N / INT_N : address and data widths of the shared array port.
//   arb_state_e    : IDLE / LOCKED encoding of the arbiter FSM.
//   clog2_min1     : index width helper that never returns 0.
package array_arbiter_pkg;

   localparam int ADDR_N = 8;
   localparam int INT_N  = 16;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   function automatic int clog2_min1(input int v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/array_arbiter_rr_pick.sv
// rr_pick
//   Purely combinational round-robin picker.
//   req_i : request vector, one bit per client
//   ptr_i : client with highest priority this cycle
//   gnt_o : one-hot grant
//   idx_o : index of the granted client
//   any_o : at least one request present
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   int j;

   // Walk ptr, ptr+1, ... wrapping at N; the first requester wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr_i) + k) % N;
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            idx_o    = IW'(j);
            gnt_o[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/array_arbiter.sv
// array_arbiter
//   Shares one array port between N clients with round-robin arbitration and
//   an optional ownership lock (bounded by MAX_LOCK cycles) for atomic RMW.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     cli_ready/valid     per-client request / completion
//     cli_addr/we/di      per-client access, client i at [i*W +: W]
//     cli_lock            keep ownership after this transfer
//     cli_do              broadcast read data (arr_do)
//     arr_ready/valid     request to / completion from the array
//     arr_addr/we/di/do   forwarded access and async read data
//     owner, locked       registered owner and LOCKED state
//     lock_err            one-cycle pulse on forced lock release
module array_arbiter
   import array_arbiter_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_LOCK = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N-1:0]                   cli_ready,
   output logic [N-1:0]                   cli_valid,
   input  logic [N*ADDR_N-1:0]            cli_addr,
   input  logic [N-1:0]                   cli_we,
   input  logic [N*INT_N-1:0]             cli_di,
   input  logic [N-1:0]                   cli_lock,
   output logic [INT_N-1:0]               cli_do,
   output logic                           arr_ready,
   input  logic                           arr_valid,
   output logic [ADDR_N-1:0]              arr_addr,
   output logic                           arr_we,
   output logic [INT_N-1:0]               arr_di,
   input  logic [INT_N-1:0]               arr_do,
   output logic [clog2_min1(N)-1:0]       owner,
   output logic                           locked,
   output logic                           lock_err
);

   localparam int AW = ADDR_N;
   localparam int DW = INT_N;
   localparam int IW = clog2_min1(N);
   localparam int CW = $clog2(MAX_LOCK + 1);

   arb_state_e    state_q;
   logic [IW-1:0] ptr_q;
   logic [IW-1:0] own_q;
   logic [CW-1:0] cnt_q;
   logic          lock_err_q;

   logic [N-1:0]  pick_gnt;
   logic [IW-1:0] pick_idx;
   logic          pick_any;

   logic [IW-1:0] w;
   logic [N-1:0]  w_vec;
   logic          have;
   logic          xfer;

   function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] x);
      return (int'(x) == N - 1) ? '0 : x + IW'(1);
   endfunction

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req_i (cli_ready),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // Winner: round-robin pick in IDLE, the lock owner only in LOCKED.
   // rst_n gates the request so a reset mid-lock idles the array port at once.
   always_comb begin
      w_vec = '0;
      if (state_q == ST_LOCKED) begin
         w            = own_q;
         w_vec[own_q] = 1'b1;
         have         = cli_ready[own_q];
      end else begin
         w     = pick_idx;
         w_vec = pick_gnt;
         have  = pick_any;
      end
      have = have & rst_n;
   end

   always_comb begin
      arr_ready = have;
      arr_addr  = '0;
      arr_we    = 1'b0;
      arr_di    = '0;
      cli_valid = '0;
      if (have) begin
         arr_addr  = cli_addr[int'(w)*AW +: AW];
         arr_we    = cli_we[w];
         arr_di    = cli_di[int'(w)*DW +: DW];
         cli_valid = w_vec & {N{arr_valid}};
      end
   end

   assign xfer     = have & arr_valid;
   assign cli_do   = arr_do;
   assign owner    = own_q;
   assign locked   = (state_q == ST_LOCKED);
   assign lock_err = lock_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         own_q      <= '0;
         cnt_q      <= '0;
         lock_err_q <= 1'b0;
      end else begin
         lock_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (xfer) begin
                  ptr_q <= inc_mod(w);
                  own_q <= w;
                  if (cli_lock[w]) begin
                     state_q <= ST_LOCKED;
                     cnt_q   <= CW'(1);
                  end
               end
            end
            ST_LOCKED: begin
               // Counter runs every locked cycle, transfer or not; hitting
               // the limit wins over a normal release (same outcome plus pulse).
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(MAX_LOCK - 1)) begin
                  state_q    <= ST_IDLE;
                  ptr_q      <= inc_mod(own_q);
                  cnt_q      <= '0;
                  lock_err_q <= 1'b1;
               end else if (xfer && !cli_lock[own_q]) begin
                  state_q <= ST_IDLE;
                  ptr_q   <= inc_mod(own_q);
                  cnt_q   <= '0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
